bypass_regfile: RTL

Parametrised register file with an integrated bypass network and load-use hazard detector, for the decode stage of the next-generation YARI pipeline. It generalises the two-port, fixed three-source decode register file. Generalised dimensions:
- register count and data width;
- number of read ports;
- number of forwarding sources;
- depth of post-commit write-back history.

It adds reset-cleared register validity and a hazard performance counter.

---
 rtl/bypass_pkg.sv | 15 +
 rtl/bypass_mux.sv | 44 ++++
 rtl/bypass_regfile.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bypass_pkg.sv
// Shared constants, tag type and helpers for the decode-stage register file and bypass network.
package bypass_pkg;

    function automatic int unsigned calc_aw(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int unsigned DEF_NREGS   = 32;
    localparam int unsigned TAG_VLD_BIT = calc_aw(DEF_NREGS);

    typedef logic [TAG_VLD_BIT:0] tag_t;

    localparam tag_t TAG_NONE = '0;

endpackage

// File: rtl/bypass_mux.sv
// Per-read-port operand selector: in-flight results, then commit history, then array data.
module bypass_mux
    import bypass_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NFWD     = 2,
    parameter int unsigned WB_DEPTH = 1
) (
    input  logic [AW:0]                 tag_i,
    input  logic [NFWD-1:0]             fwd_valid_i,
    input  logic [NFWD*(AW+1)-1:0]      fwd_tag_i,
    input  logic [NFWD*WIDTH-1:0]       fwd_res_i,
    input  logic [WB_DEPTH-1:0]         hist_vld_i,
    input  logic [WB_DEPTH*(AW+1)-1:0]  hist_tag_i,
    input  logic [WB_DEPTH*WIDTH-1:0]   hist_res_i,
    input  logic                        arr_vld_i,
    input  logic [WIDTH-1:0]            arr_data_i,
    output logic [WIDTH-1:0]            val_o
);

    localparam int unsigned TW = AW + 1;

    // Walk from lowest to highest priority so the last hit wins.
    always_comb begin
        val_o = '0;
        if (tag_i[AW]) begin
            if (arr_vld_i) begin
                val_o = arr_data_i;
            end
            for (int h = int'(WB_DEPTH) - 1; h >= 0; h--) begin
                if (hist_vld_i[h] && (hist_tag_i[h*TW +: TW] == tag_i)) begin
                    val_o = hist_res_i[h*WIDTH +: WIDTH];
                end
            end
            for (int f = int'(NFWD) - 1; f >= 0; f--) begin
                if (fwd_valid_i[f] && (fwd_tag_i[f*TW +: TW] == tag_i)) begin
                    val_o = fwd_res_i[f*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/bypass_regfile.sv
// Decode-stage register file with replicated read arrays, commit history, bypass selection,
// load-use hazard detection and performance counters.
module bypass_regfile
    import bypass_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned NFWD     = 2,
    parameter int unsigned WB_DEPTH = 1,
    localparam int unsigned AW      = calc_aw(NREGS),
    localparam int unsigned TW      = AW + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rd_en_i,
    input  logic [NREAD*TW-1:0]      rd_tag_i,
    input  logic [NREAD-1:0]         rd_haz_en_i,
    output logic [NREAD*TW-1:0]      rd_tag_q_o,
    output logic [NREAD*WIDTH-1:0]   rd_val_o,
    input  logic [NFWD-1:0]          fwd_valid_i,
    input  logic [NFWD*TW-1:0]       fwd_tag_i,
    input  logic [NFWD*WIDTH-1:0]    fwd_res_i,
    input  logic                     ld_pending_i,
    input  logic [AW:0]              ld_tag_i,
    output logic                     hazard_o,
    output logic [31:0]              perf_hazard_cycles_o,
    output logic [47:0]              perf_commits_o
);

    localparam int unsigned CP = NFWD - 1;

    logic                         commit;
    logic [AW-1:0]                wr_addr;
    logic [WIDTH-1:0]             wr_data;

    logic [NREAD*TW-1:0]          rd_tag_q;
    logic [NREAD-1:0]             rvld_q;
    logic [NREGS-1:0]             vld_q;
    logic [WB_DEPTH-1:0]          hist_vld_q, hist_vld_d;
    logic [WB_DEPTH*TW-1:0]       hist_tag_q, hist_tag_d;
    logic [WB_DEPTH*WIDTH-1:0]    hist_res_q, hist_res_d;
    logic                         hazard_q, hazard_d;
    logic [31:0]                  hcnt_q, hcnt_d;
    logic [47:0]                  ccnt_q, ccnt_d;

    assign commit  = fwd_valid_i[CP] && fwd_tag_i[CP*TW + AW];
    assign wr_addr = fwd_tag_i[CP*TW +: AW];
    assign wr_data = fwd_res_i[CP*WIDTH +: WIDTH];

    always_comb begin
        hist_vld_d = hist_vld_q;
        hist_tag_d = hist_tag_q;
        hist_res_d = hist_res_q;
        if (commit) begin
            for (int h = int'(WB_DEPTH) - 1; h > 0; h--) begin
                hist_vld_d[h]              = hist_vld_q[h-1];
                hist_tag_d[h*TW +: TW]     = hist_tag_q[(h-1)*TW +: TW];
                hist_res_d[h*WIDTH +: WIDTH] = hist_res_q[(h-1)*WIDTH +: WIDTH];
            end
            hist_vld_d[0]          = 1'b1;
            hist_tag_d[0 +: TW]    = fwd_tag_i[CP*TW +: TW];
            hist_res_d[0 +: WIDTH] = wr_data;
        end
    end

    always_comb begin
        hazard_d = 1'b0;
        for (int p = 0; p < int'(NREAD); p++) begin
            if (rd_haz_en_i[p] && rd_tag_i[p*TW + AW] && (rd_tag_i[p*TW +: TW] == ld_tag_i)) begin
                hazard_d = 1'b1;
            end
        end
        hazard_d = hazard_d && rd_en_i && ld_pending_i;
        hcnt_d   = hcnt_q + {31'd0, hazard_d};
        ccnt_d   = ccnt_q + {47'd0, fwd_valid_i[CP]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_tag_q   <= '0;
            rvld_q     <= '0;
            vld_q      <= '0;
            hist_vld_q <= '0;
            hist_tag_q <= '0;
            hist_res_q <= '0;
            hazard_q   <= 1'b0;
            hcnt_q     <= '0;
            ccnt_q     <= '0;
        end else begin
            if (rd_en_i) begin
                rd_tag_q <= rd_tag_i;
                // Validity sampled with the array read so a held operand stays coherent.
                for (int p = 0; p < int'(NREAD); p++) begin
                    rvld_q[p] <= vld_q[rd_tag_i[p*TW +: AW]];
                end
            end
            if (commit) begin
                vld_q[wr_addr] <= 1'b1;
            end
            hist_vld_q <= hist_vld_d;
            hist_tag_q <= hist_tag_d;
            hist_res_q <= hist_res_d;
            hazard_q   <= hazard_d;
            hcnt_q     <= hcnt_d;
            ccnt_q     <= ccnt_d;
        end
    end

    for (genvar p = 0; p < int'(NREAD); p++) begin : g_port
        logic [WIDTH-1:0] mem_q [NREGS];
        logic [WIDTH-1:0] rdata_q;
        logic [AW-1:0]    raddr;

        assign raddr = rd_tag_i[p*TW +: AW];

        always_ff @(posedge clk_i) begin
            if (commit) begin
                mem_q[wr_addr] <= wr_data;
            end
            if (rd_en_i) begin
                rdata_q <= mem_q[raddr];
            end
        end

        bypass_mux #(
            .WIDTH    (WIDTH),
            .AW       (AW),
            .NFWD     (NFWD),
            .WB_DEPTH (WB_DEPTH)
        ) u_mux (
            .tag_i       (rd_tag_q[p*TW +: TW]),
            .fwd_valid_i (fwd_valid_i),
            .fwd_tag_i   (fwd_tag_i),
            .fwd_res_i   (fwd_res_i),
            .hist_vld_i  (hist_vld_q),
            .hist_tag_i  (hist_tag_q),
            .hist_res_i  (hist_res_q),
            .arr_vld_i   (rvld_q[p]),
            .arr_data_i  (rdata_q),
            .val_o       (rd_val_o[p*WIDTH +: WIDTH])
        );
    end

    assign rd_tag_q_o           = rd_tag_q;
    assign hazard_o             = hazard_q;
    assign perf_hazard_cycles_o = hcnt_q;
    assign perf_commits_o       = ccnt_q;

endmodule
